// File: rtl/arb8_rr.sv
// arb8_rr: round-robin arbiter sharing one resource among 8 requesters.
// The registered sel drives a DMux8Way select and grant is the matching
// one-hot enable. An optional hold limit forces rotation so no requester
// can keep the resource indefinitely while others wait.
module arb8_rr #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       busy,
   output logic       timeout
);

   // Counter must reach MAX_HOLD; keep at least one bit when the limit is off.
   localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [2:0]    ptr;
   logic [CW-1:0] hold_cnt;

   logic          ptr_found;
   logic [2:0]    ptr_pick;
   logic          next_found;
   logic [2:0]    next_pick;
   logic [2:0]    next_base;

   // Rotating priority search: first requester at or after p, wrapping 7 -> 0.
   // Walking the offsets from high to low lets the smallest offset win.
   function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         idx = p + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Two candidate searches: from the stored pointer (used when idle) and from
   // just past the current owner (used on release or expiry, owner searched last).
   always_comb begin
      next_base               = sel + 3'd1;
      {ptr_found, ptr_pick}   = pick(req, ptr);
      {next_found, next_pick} = pick(req, next_base);
   end

   // Arbitration state machine; all outputs are registered here so grant
   // can only change on a clock edge and never shows two bits at once.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= 8'h00;
         sel      <= 3'd0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= 3'd0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (ptr_found) begin
                  grant    <= 8'h01 << ptr_pick;
                  sel      <= ptr_pick;
                  busy     <= 1'b1;
                  hold_cnt <= CW'(1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (!req[sel]) begin
                  ptr <= next_base;
                  if (next_found) begin
                     grant    <= 8'h01 << next_pick;
                     sel      <= next_pick;
                     hold_cnt <= CW'(1);
                  end else begin
                     grant    <= 8'h00;
                     busy     <= 1'b0;
                     hold_cnt <= '0;
                     state    <= IDLE;
                  end
               end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
                  timeout  <= 1'b1;
                  ptr      <= next_base;
                  grant    <= 8'h01 << next_pick;
                  sel      <= next_pick;
                  hold_cnt <= CW'(1);
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arb8_rr.sv
// tb_arb8_rr: scoreboard bench for arb8_rr. Expected output tuples are pushed
// when each edge's stimulus is driven and popped/compared one step after it.
module tb_arb8_rr;

   logic       clock;
   logic       reset;
   logic [7:0] req;

   logic [7:0] grant4,  grant16;
   logic [2:0] sel4,    sel16;
   logic       busy4,   busy16;
   logic       timeout4, timeout16;

   logic [12:0] obs4, obs16;
   logic [12:0] sb[$];
   logic [12:0] exp;

   int checks = 0;
   int passed = 0;

   arb8_rr #(.MAX_HOLD(4)) dut4 (
      .clock(clock), .reset(reset), .req(req),
      .grant(grant4), .sel(sel4), .busy(busy4), .timeout(timeout4)
   );

   arb8_rr dut16 (
      .clock(clock), .reset(reset), .req(req),
      .grant(grant16), .sel(sel16), .busy(busy16), .timeout(timeout16)
   );

   assign obs4  = {grant4, sel4, busy4, timeout4};
   assign obs16 = {grant16, sel16, busy16, timeout16};

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Packs {grant, sel, busy, timeout} into one scoreboard entry.
   function automatic logic [12:0] pk(input logic [7:0] g, input logic [2:0] s,
                                      input logic b, input logic t);
      return {g, s, b, t};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      req   = 8'h00;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 8'hFF;
      sb.push_back(pk(8'h00, 3'd0, 1'b0, 1'b0));
      @(posedge clock); #1;
      exp = sb.pop_front();
      checks++;
      if (obs4 !== exp)
         $display("[TB] FAIL reset: got %h required %h", obs4, exp);
      else passed++;
      checks++;
      if (obs16 !== exp)
         $display("[TB] FAIL reset16: got %h required %h", obs16, exp);
      else passed++;
      reset = 1'b0;
      req   = 8'h00;
   endtask

   task automatic test_single();
      logic [7:0] rv [2];
      rv[0] = 8'h04; rv[1] = 8'h00;
      do_reset();
      for (int e = 0; e < 2; e++) begin
         req = rv[e];
         if (e == 0) sb.push_back(pk(8'h04, 3'd2, 1'b1, 1'b0));
         else        sb.push_back(pk(8'h00, 3'd2, 1'b0, 1'b0));
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs4 !== exp)
            $display("[TB] FAIL single edge %0d: got %h required %h", e, obs4, exp);
         else passed++;
      end
   endtask

   // Every requester active; each owner gives up after three granted cycles
   // and re-raises right afterwards, so the order must wrap back to 0.
   task automatic test_rotation();
      int k, prev;
      do_reset();
      for (int n = 0; n < 9; n++) begin
         k    = n % 8;
         prev = (n + 7) % 8;
         for (int j = 0; j < 3; j++) begin
            req = 8'hFF;
            if (j == 0 && n > 0) req[prev] = 1'b0;
            sb.push_back(pk(8'h01 << k, 3'(k), 1'b1, 1'b0));
            @(posedge clock); #1;
            exp = sb.pop_front();
            checks++;
            if (obs4 !== exp)
               $display("[TB] FAIL rotation owner %0d cyc %0d: got %h required %h", k, j, obs4, exp);
            else passed++;
         end
      end
      req = 8'h00;
   endtask

   // Two steady requesters with a hold limit of 4 alternate with a timeout pulse.
   task automatic test_expire();
      logic [7:0] g;
      do_reset();
      req = 8'h03;
      for (int e = 1; e <= 9; e++) begin
         g = (e <= 4 || e == 9) ? 8'h01 : 8'h02;
         sb.push_back(pk(g, (g == 8'h02) ? 3'd1 : 3'd0, 1'b1, (e == 5 || e == 9)));
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs4 !== exp)
            $display("[TB] FAIL expire edge %0d: got %h required %h", e, obs4, exp);
         else passed++;
      end
      req = 8'h00;
   endtask

   // A lone requester keeps the grant across expiries; only timeout pulses.
   task automatic test_lone_expire();
      do_reset();
      req = 8'h80;
      for (int e = 1; e <= 13; e++) begin
         sb.push_back(pk(8'h80, 3'd7, 1'b1, (e > 1 && (e - 1) % 4 == 0)));
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs4 !== exp)
            $display("[TB] FAIL lone edge %0d: got %h required %h", e, obs4, exp);
         else passed++;
      end
      req = 8'h00;
   endtask

   // Reset mid-grant clears everything and the pointer restarts at 0.
   task automatic test_reset_midgrant();
      do_reset();
      for (int e = 0; e < 4; e++) begin
         case (e)
            0: begin req = 8'h20; reset = 1'b0; sb.push_back(pk(8'h20, 3'd5, 1'b1, 1'b0)); end
            1: begin req = 8'hA0; reset = 1'b1; sb.push_back(pk(8'h00, 3'd0, 1'b0, 1'b0)); end
            2: begin req = 8'hA0; reset = 1'b0; sb.push_back(pk(8'h20, 3'd5, 1'b1, 1'b0)); end
            default: begin req = 8'hA0; reset = 1'b0; sb.push_back(pk(8'h20, 3'd5, 1'b1, 1'b0)); end
         endcase
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs4 !== exp)
            $display("[TB] FAIL reset_mid edge %0d: got %h required %h", e, obs4, exp);
         else passed++;
      end
      reset = 1'b0;
      req   = 8'h00;
   endtask

   // Release to idle keeps sel; the pointer then sits just past the old owner.
   // With ptr=4, req=09 searches 4..7 then 0 and lands on requester 0;
   // req=18 lands on requester 4 rather than 3.
   task automatic test_release_idle();
      logic [7:0] last [2];
      logic [7:0] gexp [2];
      logic [2:0] sexp [2];
      last[0] = 8'h09; gexp[0] = 8'h01; sexp[0] = 3'd0;
      last[1] = 8'h18; gexp[1] = 8'h10; sexp[1] = 3'd4;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         for (int e = 0; e < 4; e++) begin
            case (e)
               0: begin req = 8'h08; sb.push_back(pk(8'h08, 3'd3, 1'b1, 1'b0)); end
               1: begin req = 8'h00; sb.push_back(pk(8'h00, 3'd3, 1'b0, 1'b0)); end
               2: begin req = 8'h00; sb.push_back(pk(8'h00, 3'd3, 1'b0, 1'b0)); end
               default: begin req = last[v]; sb.push_back(pk(gexp[v], sexp[v], 1'b1, 1'b0)); end
            endcase
            @(posedge clock); #1;
            exp = sb.pop_front();
            checks++;
            if (obs4 !== exp)
               $display("[TB] FAIL release_idle v%0d edge %0d: got %h required %h", v, e, obs4, exp);
            else passed++;
         end
      end
      req = 8'h00;
   endtask

   // A request raised mid-grant waits; the handover on release has no bubble.
   task automatic test_back_to_back();
      do_reset();
      for (int e = 0; e < 3; e++) begin
         case (e)
            0: begin req = 8'h04; sb.push_back(pk(8'h04, 3'd2, 1'b1, 1'b0)); end
            1: begin req = 8'h05; sb.push_back(pk(8'h04, 3'd2, 1'b1, 1'b0)); end
            default: begin req = 8'h01; sb.push_back(pk(8'h01, 3'd0, 1'b1, 1'b0)); end
         endcase
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs4 !== exp)
            $display("[TB] FAIL back_to_back edge %0d: got %h required %h", e, obs4, exp);
         else passed++;
      end
      req = 8'h00;
   endtask

   // Default hold limit of 16 on the second instance.
   task automatic test_default_hold();
      do_reset();
      req = 8'h03;
      for (int e = 1; e <= 17; e++) begin
         if (e <= 16) sb.push_back(pk(8'h01, 3'd0, 1'b1, 1'b0));
         else         sb.push_back(pk(8'h02, 3'd1, 1'b1, 1'b1));
         @(posedge clock); #1;
         exp = sb.pop_front();
         checks++;
         if (obs16 !== exp)
            $display("[TB] FAIL hold16 edge %0d: got %h required %h", e, obs16, exp);
         else passed++;
      end
      req = 8'h00;
   endtask

   initial begin
      reset = 1'b1;
      req   = 8'h00;
      #1;
      test_reset();
      test_single();
      test_rotation();
      test_expire();
      test_lone_expire();
      test_reset_midgrant();
      test_release_idle();
      test_back_to_back();
      test_default_hold();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
